// File: rtl/multicycle_alu.sv
// 32-bit ALU with single-cycle arithmetic/logic ops and a bit-serial shifter
// that shifts one position per cycle; results and flags are registered.
module multicycle_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] ALUResult,
  output logic        Zero,
  output logic        Neg,
  output logic        Carry,
  output logic        Overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_SRA = 3'b100, OP_SRL = 3'b101, OP_SLL = 3'b110, OP_XOR = 3'b111
  } op_t;

  state_t      state;
  op_t         op;
  op_t         op_in;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [4:0]  cnt;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic [31:0] res;
  logic        res_c;
  logic        res_v;
  logic        is_shift;
  logic        wr;

  always_comb begin
    op_in    = op_t'(ALUControl);
    is_shift = (op_in == OP_SRA) || (op_in == OP_SRL) || (op_in == OP_SLL);
    // Subtract shares the adder as A + ~B + 1; carry-out then means no borrow.
    b_eff    = (op_in == OP_SUB) ? ~SrcB : SrcB;
    sum      = {1'b0, SrcA} + {1'b0, b_eff} + {32'd0, op_in == OP_SUB};

    case (op)
      OP_SRA:  acc_next = {acc[31], acc[31:1]};
      OP_SRL:  acc_next = {1'b0, acc[31:1]};
      default: acc_next = {acc[30:0], 1'b0};
    endcase

    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    wr    = 1'b0;
    if (state == SHIFT) begin
      res = acc_next;
      wr  = (cnt == 5'd1);
    end else if (start) begin
      wr = !is_shift || (SrcB[4:0] == 5'd0);
      case (op_in)
        OP_ADD, OP_SUB: begin
          res   = sum[31:0];
          res_c = sum[32];
          res_v = (SrcA[31] == b_eff[31]) && (sum[31] != SrcA[31]);
        end
        OP_AND:  res = SrcA & SrcB;
        OP_OR:   res = SrcA | SrcB;
        OP_XOR:  res = SrcA ^ SrcB;
        default: res = SrcA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_ADD;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      done <= wr;
      if (wr) begin
        ALUResult <= res;
        Zero      <= (res == '0);
        Neg       <= res[31];
        Carry     <= res_c;
        Overflow  <= res_v;
      end
      case (state)
        IDLE: begin
          if (start) begin
            op  <= op_in;
            acc <= SrcA;
            cnt <= SrcB[4:0];
            if (is_shift && (SrcB[4:0] != 5'd0)) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus random
// traffic, compared every cycle against a transaction-level model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  ALUControl = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy, done, Zero, Neg, Carry, Overflow;
  logic [31:0] ALUResult;

  int errors = 0;
  int checks = 0;

  multicycle_alu dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .ALUResult(ALUResult),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: whole-operation result from plain arithmetic.
  function automatic void compute(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v);
    longint unsigned s;
    int n;
    n = int'(b[4:0]);
    c = 1'b0;
    v = 1'b0;
    case (opc)
      3'd0: begin
        s = longint'(a) + longint'(b);
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = $unsigned($signed(a) >>> n);
      3'd5: r = a >> n;
      3'd6: r = a << n;
      default: r = a ^ b;
    endcase
  endfunction

  logic [31:0] m_res, m_pend;
  logic        m_z, m_n, m_c, m_v, m_busy, m_done;
  int          m_left;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic c, v;
    if (reset) begin
      m_res = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
      m_busy = 0; m_done = 0; m_left = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_res = m_pend; m_z = (m_pend == 0); m_n = m_pend[31]; m_c = 0; m_v = 0;
          m_done = 1;
        end
      end else if (start) begin
        compute(ALUControl, SrcA, SrcB, r, c, v);
        if (ALUControl inside {3'd4, 3'd5, 3'd6} && SrcB[4:0] != 0) begin
          m_left = int'(SrcB[4:0]);
          m_pend = r;
        end else begin
          m_res = r; m_z = (r == 0); m_n = r[31]; m_c = c; m_v = v;
          m_done = 1;
        end
      end
      m_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("result", ALUResult, m_res);
      chk("flags", {Zero, Neg, Carry, Overflow}, {m_z, m_n, m_c, m_v});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Launch one op in the current cycle and measure the cycles until done.
  task automatic run_op(input string name, input logic [2:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                        input int elat);
    int lat, nbusy;
    ALUControl = opc; SrcA = a; SrcB = b; start = 1'b1;
    step();
    start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busycycles"}, nbusy, elat - 1);
    chk({name, "_busy_at_done"}, busy, 1'b0);
    chk({name, "_result"}, ALUResult, er);
    chk({name, "_ZNCV"}, {Zero, Neg, Carry, Overflow}, ef);
  endtask

  logic [31:0] specials [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};

  initial begin
    step();
    do_reset();
    chk("reset_result", ALUResult, 32'h0);
    chk("reset_flags", {Zero, Neg, Carry, Overflow}, 4'b0000);
    chk("reset_busy_done", {busy, done}, 2'b00);

    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1);
    run_op("sub_zero", 3'd1, 32'h5, 32'h5, 32'h0, 4'b1010, 1);
    run_op("sub_borrow", 3'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b0100, 1);
    run_op("sra4", 3'd4, 32'h80000000, 32'h4, 32'hF8000000, 4'b0100, 5);
    run_op("srl4", 3'd5, 32'h80000000, 32'h4, 32'h08000000, 4'b0000, 5);
    run_op("sll0", 3'd6, 32'h12345678, 32'h0, 32'h12345678, 4'b0000, 1);
    run_op("sll31", 3'd6, 32'h00000001, 32'd31, 32'h80000000, 4'b0100, 32);
    run_op("and", 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1);
    run_op("xor", 3'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 4'b1000, 1);

    // Reset in the middle of an 8-step srl aborts it.
    ALUControl = 3'd5; SrcA = 32'hFFFF0000; SrcB = 32'd8; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy_done", {busy, done}, 2'b00);
    chk("abort_result", ALUResult, 32'h0);
    chk("abort_flags", {Zero, Neg, Carry, Overflow}, 4'b0000);
    ALUControl = 3'd0; SrcA = 32'd2; SrcB = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("post_abort_done", done, 1'b1);
    chk("post_abort_result", ALUResult, 32'd5);
    step(); step(); step(); step();
    chk("no_stale_done", {busy, done}, 2'b00);
    chk("held_result", ALUResult, 32'd5);

    // start held through a 3-step shift, then accepted in the done cycle.
    ALUControl = 3'd6; SrcA = 32'h1; SrcB = 32'd3; start = 1'b1;
    step();
    ALUControl = 3'd0; SrcA = 32'h10; SrcB = 32'h20;
    chk("held_busy1", busy, 1'b1);
    step();
    step();
    chk("held_busy3", busy, 1'b1);
    step();
    chk("held_done", {busy, done}, 2'b01);
    chk("held_result_sll", ALUResult, 32'h8);
    step();
    start = 1'b0;
    chk("second_done", done, 1'b1);
    chk("second_result", ALUResult, 32'h30);
    step();
    chk("second_done_clear", done, 1'b0);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      ALUControl = 3'($urandom);
      SrcA = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      SrcB = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 1) == 1) SrcB[4:0] = 5'($urandom_range(0, 3));
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
Parameters: none; datapath is fixed at 32 bits and shift amount is SrcB[4:0].
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 ALUControl  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 sra, 101 srl, 110 sll, 111 xor.
REQ-006 SrcA  input  32  operand A; shift source for shift operations.
REQ-007 SrcB  input  32  operand B; bits [4:0] give the shift amount for shift operations.
REQ-008 busy  output  1  high while a shift is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse; ALUResult and flags are valid from this cycle on.
REQ-010 ALUResult  output  32  registered result, held until the next done.
REQ-011 Zero, Neg, Carry, Overflow  output  1 each  registered flags, updated only together with ALUResult.

Function
REQ-012 The block SHALL have two states: IDLE and SHIFT.
REQ-013 IDLE with start=1 SHALL latch ALUControl, SrcA and SrcB[4:0] on that edge; start=0 leaves all outputs unchanged.
REQ-014 Non-shift op accepted in cycle T SHALL write ALUResult and flags on the T edge, pulse done in cycle T+1, and stay in IDLE.
REQ-015 Shift op with shamt 0 SHALL behave as REQ-014, with ALUResult=SrcA.
REQ-016 Shift op with shamt n>0 SHALL load the accumulator with SrcA and the counter with n, then enter SHIFT.
REQ-017 Each SHIFT cycle SHALL shift the accumulator by exactly 1 bit and decrement the counter.
REQ-018 Shift semantics: sll fills with 0 from the LSB; srl fills with 0 from the MSB; sra replicates bit 31.
REQ-019 SHIFT with counter==1 SHALL write the final shifted value to ALUResult, pulse done next cycle, and return to IDLE.
REQ-020 Shift timing: busy high in cycles T+1..T+n; done high in cycle T+n+1 with busy low.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start during a done cycle SHALL be accepted, since the block is already in IDLE.
REQ-023 Arithmetic: add = A+B mod 2^32; sub = A+~B+1 mod 2^32.
REQ-024 Carry SHALL be the bit-32 carry-out for add and sub (sub: 1 = no borrow); Carry SHALL be 0 for all other ops.
REQ-025 Overflow SHALL be the signed overflow for add (operands same sign, result differs) and sub (operands differ in sign, result sign differs from A); Overflow SHALL be 0 otherwise.
REQ-026 Zero SHALL be (ALUResult==0) and Neg SHALL be ALUResult[31], for all ops.
REQ-027 Inputs SHALL be don't-care outside the accepting edge; changing them during SHIFT SHALL NOT affect the result.

Reset
REQ-028 reset=1 SHALL force IDLE, busy=0, done=0, ALUResult=0, and Zero=Neg=Carry=Overflow=0, with counter and accumulator cleared.
REQ-029 reset SHALL take priority over start and over SHIFT progress.
REQ-030 reset asserted mid-shift SHALL abort the operation: no done pulse, result discarded.
REQ-031 The first start after reset deasserts SHALL be accepted.

Verification
REQ-032 add 0x7FFFFFFF+0x00000001, start in T -> done in T+1; ALUResult=0x80000000, Overflow=1, Neg=1, Carry=0, Zero=0; busy never high.
REQ-033 sub 0x00000005-0x00000005 -> ALUResult=0, Zero=1, Carry=1, Overflow=0; sub 0-1 -> 0xFFFFFFFF, Carry=0, Neg=1.
REQ-034 sra SrcA=0x80000000, SrcB=4 -> busy high in T+1..T+4, done in T+5, ALUResult=0xF8000000; srl on the same operands -> 0x08000000.
REQ-035 sll SrcB=0 -> done in T+1, ALUResult=SrcA; sll 0x00000001 by 31 -> done in T+32, ALUResult=0x80000000, Neg=1.
REQ-036 srl by 8 with reset pulsed in T+3 -> T+4 shows busy=0, done=0, all outputs 0; no done in T+9; start in T+4 accepted normally.
REQ-037 start held high through a 3-cycle shift -> only the first request executes; start in the done cycle launches a second op whose done arrives per REQ-014/REQ-020.
